// File: rtl/lcd_char_arbiter.sv
// rtl/lcd_char_arbiter.sv - two-requester character arbiter feeding an LCD controller
//
// Purpose: accepts character-write requests from two requesters, latches the
// winner's character into info, strobes enviar for one cycle and then waits
// at least GAP_CYCLES cycles (and until the LCD is ready) before serving the
// next request.
//
// Optional feature macro: LCD_ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests alternate (requester not granted last wins)
//   undefined : req0 always wins simultaneous requests
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   reset       in   asynchronous active-low reset
//   lcd_ready   in   LCD controller idle and able to accept a character
//   req0/req1   in   character-write requests
//   data0/data1 in   [7:0] characters offered by each requester
//   gnt0/gnt1   out  one-cycle acknowledge that the requester's data was latched
//   enviar      out  one-cycle send strobe to the LCD controller
//   info        out  [7:0] character presented to the LCD controller
//   busy        out  high in every state except IDLE
//   char_count  out  [CNT_W-1:0] running count of issued characters (wraps)

module lcd_char_arbiter #(
  parameter logic [31:0] GAP_CYCLES = 32'd2000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lcd_ready,
  input  logic             req0,
  input  logic             req1,
  input  logic [7:0]       data0,
  input  logic [7:0]       data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             enviar,
  output logic [7:0]       info,
  output logic             busy,
  output logic [CNT_W-1:0] char_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       info_q, info_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hold_q, hold_d;
  logic             pick1;
  logic             hold_done;

  // Counter sits at GAP_CYCLES-1 once the minimum gap has elapsed.
  assign hold_done = (hold_q == (GAP_CYCLES - 32'd1));

`ifdef LCD_ARB_ROUND_ROBIN_EN
  // last_q = 1 means requester 1 received the most recent grant.
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (gnt1_d) begin
      last_d = 1'b1;
    end else if (gnt0_d) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // On a tie requester 1 wins only if requester 0 was granted last.
  assign pick1 = req1 & (~req0 | ~last_q);
`else
  assign pick1 = req1 & ~req0;
`endif

  always_comb begin
    state_d = state_q;
    info_d  = info_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (lcd_ready && (req0 || req1)) begin
          state_d = S_ISSUE;
          if (pick1) begin
            info_d = data1;
            gnt1_d = 1'b1;
          end else begin
            info_d = data0;
            gnt0_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        hold_d  = 32'd0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!hold_done) begin
          hold_d = hold_q + 32'd1;
        end
        if (hold_done && lcd_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      info_q  <= 8'h00;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      info_q  <= info_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Decoded from state so both fall as soon as reset asserts.
  assign enviar     = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign info       = info_q;
  assign char_count = cnt_q;

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// tb/tb_lcd_char_arbiter.sv - directed self-checking bench for lcd_char_arbiter

module tb_lcd_char_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_ready;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, enviar, busy;
  logic [7:0] info;
  logic [3:0] char_count;

  int errors = 0;
  int checks = 0;

  lcd_char_arbiter #(
    .GAP_CYCLES(32'd4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lcd_ready(lcd_ready),
    .req0(req0),
    .req1(req1),
    .data0(data0),
    .data1(data1),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .enviar(enviar),
    .info(info),
    .busy(busy),
    .char_count(char_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0  = 1'b0;
    req1  = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%0b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++; if (enviar !== 1'b0) begin errors++; $display("FAIL reset_enviar: got %0b required 0", enviar); end
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %0b%0b required 00", gnt0, gnt1); end
    checks++; if (info !== 8'h00) begin errors++; $display("FAIL reset_info: got %0h required 00", info); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++; if (char_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", char_count); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single();
    lcd_ready = 1'b1;
    data0 = 8'h41;
    req0  = 1'b1;
    tick();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt: got %0b%0b required 10", gnt0, gnt1); end
    checks++; if (enviar !== 1'b1) begin errors++; $display("FAIL single_enviar: got %0b required 1", enviar); end
    checks++; if (info !== 8'h41) begin errors++; $display("FAIL single_info: got %0h required 41", info); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b required 1", busy); end
    req0 = 1'b0;
    tick();
    checks++; if (enviar !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL single_pulse_width: enviar=%0b gnt0=%0b required 0 0", enviar, gnt0); end
    checks++; if (char_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d required 1", char_count); end
    tick(); tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_hold_busy: got %0b required 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_back_idle: got %0b required 0", busy); end
    tick();
    checks++; if (busy !== 1'b0 || info !== 8'h41) begin errors++; $display("FAIL single_idle_hold_info: busy=%0b info=%0h required 0 41", busy, info); end
  endtask

  task automatic test_lone_req1();
    data1 = 8'h5A;
    req1  = 1'b1;
    tick();
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL lone1_gnt: got %0b%0b required 01", gnt0, gnt1); end
    checks++; if (info !== 8'h5A) begin errors++; $display("FAIL lone1_info: got %0h required 5a", info); end
    req1 = 1'b0;
    wait_idle("lone1");
    checks++; if (char_count !== 4'd2) begin errors++; $display("FAIL lone1_count: got %0d required 2", char_count); end
  endtask

  task automatic test_tie();
    int n;
    int last_cyc;
    logic [3:0] who;
    logic [3:0] exp_who;
`ifdef LCD_ARB_ROUND_ROBIN_EN
    exp_who = 4'b1010;
`else
    exp_who = 4'b0000;
`endif
    do_reset();
    data0 = 8'h30;
    data1 = 8'h31;
    req0  = 1'b1;
    req1  = 1'b1;
    n = 0;
    last_cyc = 0;
    who = 4'b0000;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      tick();
      checks++;
      if (gnt0 === 1'b1 && gnt1 === 1'b1) begin errors++; $display("FAIL tie_both_gnt at cycle %0d: got 11 required not both", cyc); end
      if (enviar === 1'b1) begin
        who[n] = gnt1;
        checks++;
        if (info !== (exp_who[n] ? 8'h31 : 8'h30)) begin
          errors++; $display("FAIL tie_info[%0d]: got %0h required %0h", n, info, exp_who[n] ? 8'h31 : 8'h30);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc != 6) begin errors++; $display("FAIL tie_spacing[%0d]: got %0d required 6", n, cyc - last_cyc); end
        end
        last_cyc = cyc;
        n++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL tie_pulses: got %0d required 4", n); end
    checks++; if (who !== exp_who) begin errors++; $display("FAIL tie_order: got %b required %b", who, exp_who); end
    wait_idle("tie");
  endtask

  task automatic test_stall();
    data0 = 8'h55;
    req0  = 1'b1;
    tick();
    checks++; if (enviar !== 1'b1) begin errors++; $display("FAIL stall_issue: got %0b required 1", enviar); end
    req0 = 1'b0;
    lcd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || enviar !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: busy=%0b enviar=%0b required 1 0", i, busy, enviar); end
    end
    lcd_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_release: got %0b required 0", busy); end
  endtask

  task automatic test_reset_mid_hold();
    data0 = 8'h22;
    req0  = 1'b1;
    tick();
    checks++; if (enviar !== 1'b1) begin errors++; $display("FAIL rst_hold_issue: got %0b required 1", enviar); end
    req0 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || enviar !== 1'b0) begin errors++; $display("FAIL rst_hold_async: busy=%0b enviar=%0b required 0 0", busy, enviar); end
    checks++; if (info !== 8'h00 || char_count !== 4'd0) begin errors++; $display("FAIL rst_hold_regs: info=%0h count=%0d required 00 0", info, char_count); end
    tick();
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || enviar !== 1'b0) begin errors++; $display("FAIL rst_hold_quiet: gnt=%0b%0b enviar=%0b required 00 0", gnt0, gnt1, enviar); end
    reset = 1'b1;
    data1 = 8'h5A;
    req1  = 1'b1;
    tick();
    checks++; if (gnt1 !== 1'b1 || info !== 8'h5A) begin errors++; $display("FAIL rst_hold_regrant: gnt1=%0b info=%0h required 1 5a", gnt1, info); end
    req1 = 1'b0;
    tick();
    checks++; if (char_count !== 4'd1) begin errors++; $display("FAIL rst_hold_count: got %0d required 1", char_count); end
    wait_idle("rst_hold");
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    data0 = 8'h77;
    req0  = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 17; cyc++) begin
      tick();
      if (enviar === 1'b1) n++;
    end
    req0 = 1'b0;
    checks++; if (n != 17) begin errors++; $display("FAIL wrap_pulses: got %0d required 17", n); end
    tick();
    checks++; if (char_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d required 1", char_count); end
    wait_idle("wrap");
  endtask

  initial begin
    reset     = 1'b1;
    lcd_ready = 1'b1;
    req0      = 1'b0;
    req1      = 1'b0;
    data0     = 8'h00;
    data1     = 8'h00;
    test_reset();
    test_single();
    test_lone_req1();
    test_tie();
    test_stall();
    test_reset_mid_hold();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
